fixed_point_mac_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point multiplier/accumulator for neuron dot products in the neural datapath.
- Operands and result are Q(INT_W.FRAC_W) two's complement.
- Provides a full-precision product, selectable rounding, saturation with overflow flag, an optional accumulate mode over first/last-delimited groups, and valid/ready handshaking on both sides.

---
 rtl/fixed_point_mac_pipe_if.sv | 28 ++
 rtl/fixed_point_mac_pipe.sv | 150 +++++++++++++++
 tb/tb_fixed_point_mac_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_mac_pipe_if.sv
// Valid/ready bus for the fixed-point MAC pipeline: operand beat in, scaled result out.
// The master drives beats and accepts results; the slave is the MAC.
interface fixed_point_mac_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dataa;
  logic [W-1:0] datab;
  logic         acc_mode;
  logic         first;
  logic         last;
  logic         round_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;

  modport master (
    output in_valid, dataa, datab, acc_mode, first, last, round_mode, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, dataa, datab, acc_mode, first, last, round_mode, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/fixed_point_mac_pipe.sv
// Three-stage signed Q(INT_W.FRAC_W) multiply/accumulate with rounding and saturation.
// Stages: operand capture, full-precision product, scale/saturate/accumulate into the output registers.
module fixed_point_mac_pipe #(
  parameter int INT_W   = 16,
  parameter int FRAC_W  = 16,
  parameter int GUARD_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fixed_point_mac_pipe_if.slave  bus
);

  localparam int W    = INT_W + FRAC_W;
  localparam int ACCW = W + GUARD_W;
  localparam int PW   = 2 * W;

  localparam logic [W-1:0]    RES_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    RES_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  // Range limits sign-extended to the scaled-product width so they compare directly.
  localparam logic signed [PW:0] RES_MAX_X = {{(PW+1-W){1'b0}}, RES_MAX};
  localparam logic signed [PW:0] RES_MIN_X = {{(PW+1-W){1'b1}}, RES_MIN};
  localparam logic signed [PW:0] ACC_MAX_X = {{(PW+1-ACCW){1'b0}}, ACC_MAX};
  localparam logic signed [PW:0] ACC_MIN_X = {{(PW+1-ACCW){1'b1}}, ACC_MIN};
  localparam logic signed [PW:0] HALF      = {{(PW+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef struct packed {
    logic acc_mode;
    logic first;
    logic last;
    logic round_mode;
  } side_t;

  logic                   stall;
  logic                   s1_valid;
  logic signed [W-1:0]    s1_a;
  logic signed [W-1:0]    s1_b;
  side_t                  s1_side;
  logic                   s2_valid;
  logic signed [PW-1:0]   s2_p;
  side_t                  s2_side;

  logic                   out_valid_q;
  logic [W-1:0]           result_q;
  logic                   overflow_q;
  logic [ACCW-1:0]        acc_q;
  logic                   sticky_q;

  assign stall         = out_valid_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are qualified by the stage valids.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_a    <= bus.dataa;
      s1_b    <= bus.datab;
      s1_side <= '{acc_mode: bus.acc_mode, first: bus.first, last: bus.last,
                   round_mode: bus.round_mode};
      s2_p    <= PW'(s1_a) * PW'(s1_b);
      s2_side <= s1_side;
    end
  end

  logic signed [PW:0]   p_ext;
  logic signed [PW:0]   q_full;
  logic                 q_hi_w, q_lo_w, q_hi_a, q_lo_a;
  logic [W-1:0]         q_w;
  logic [ACCW-1:0]      q_a;
  logic [ACCW-1:0]      acc_base;
  logic [ACCW:0]        acc_sum;
  logic                 sum_ovf;
  logic [ACCW-1:0]      acc_new;
  logic                 sticky_new;
  logic [ACCW-W:0]      acc_upper;
  logic                 fin_ovf;
  logic [W-1:0]         fin_res;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    p_ext    = '0;
    q_full   = '0;
    acc_base = '0;
    p_ext    = {s2_p[PW-1], s2_p} + (s2_side.round_mode ? HALF : '0);
    q_full   = p_ext >>> FRAC_W;

    q_hi_w = q_full > RES_MAX_X;
    q_lo_w = q_full < RES_MIN_X;
    q_w    = q_hi_w ? RES_MAX : (q_lo_w ? RES_MIN : q_full[W-1:0]);

    q_hi_a = q_full > ACC_MAX_X;
    q_lo_a = q_full < ACC_MIN_X;
    q_a    = q_hi_a ? ACC_MAX : (q_lo_a ? ACC_MIN : q_full[ACCW-1:0]);

    // A first beat starts from zero, which also discards any open partial group.
    if (!s2_side.first) acc_base = acc_q;
    acc_sum    = {acc_base[ACCW-1], acc_base} + {q_a[ACCW-1], q_a};
    sum_ovf    = acc_sum[ACCW] ^ acc_sum[ACCW-1];
    acc_new    = sum_ovf ? (acc_sum[ACCW] ? ACC_MIN : ACC_MAX) : acc_sum[ACCW-1:0];
    sticky_new = (sticky_q && !s2_side.first) || q_hi_a || q_lo_a || sum_ovf;

    acc_upper = acc_new[ACCW-1:W-1];
    fin_ovf   = !((&acc_upper) || !(|acc_upper));
    fin_res   = fin_ovf ? (acc_new[ACCW-1] ? RES_MIN : RES_MAX) : acc_new[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= 1'b0;
      if (s2_valid) begin
        if (!s2_side.acc_mode) begin
          out_valid_q <= 1'b1;
          result_q    <= q_w;
          overflow_q  <= q_hi_w || q_lo_w;
        end else if (s2_side.last) begin
          out_valid_q <= 1'b1;
          result_q    <= fin_res;
          overflow_q  <= sticky_new || fin_ovf;
          acc_q       <= '0;
          sticky_q    <= 1'b0;
        end else begin
          acc_q       <= acc_new;
          sticky_q    <= sticky_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_mac_pipe.sv
// Directed bench for fixed_point_mac_pipe at default Q16.16 with hand-computed expectations.
// A negedge monitor records every accepted output; the stimulus sequence pops and compares them.
module tb_fixed_point_mac_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] got_res[$];
  logic        got_ovf[$];
  logic        bp_phase = 1'b0;
  logic        stalled_prev = 1'b0;
  logic [32:0] held = '0;

  fixed_point_mac_pipe_if #(.W(32)) bus ();

  fixed_point_mac_pipe #(.INT_W(16), .FRAC_W(16), .GUARD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_res.push_back(bus.result);
      got_ovf.push_back(bus.overflow);
    end
    if (bp_phase) begin
      check("in_ready_vs_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (stalled_prev) check("stall_stable", {bus.out_valid, bus.result, bus.overflow}, {1'b1, held});
      stalled_prev <= bus.out_valid && !bus.out_ready;
      held         <= {bus.result, bus.overflow};
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic am, input logic f, input logic l, input logic r);
    bus.dataa = a; bus.datab = b;
    bus.acc_mode = am; bus.first = f; bus.last = l; bus.round_mode = r;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int k = 0;
    while (got_res.size() < n && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] er, input logic eo);
    logic [31:0] r;
    logic        o;
    check({tag, "_present"}, 64'(got_res.size() > 0), 64'd1);
    if (got_res.size() > 0) begin
      r = got_res.pop_front();
      o = got_ovf.pop_front();
      check({tag, "_result"}, r, er);
      check({tag, "_overflow"}, o, eo);
    end
  endtask

  initial begin
    int n;
    int sent;
    int cyc;
    logic acc_ok;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.dataa = '0; bus.datab = '0;
    bus.acc_mode = 1'b0; bus.first = 1'b0; bus.last = 1'b0; bus.round_mode = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_result", bus.result, 32'h0);
    check("reset_overflow", bus.overflow, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Latency: in_valid cycle counts as 0, out_valid must appear in cycle 3.
    bus.dataa = 32'h00018000; bus.datab = 32'h00020000;
    bus.acc_mode = 1'b0; bus.first = 1'b0; bus.last = 1'b0; bus.round_mode = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n++;
    end while (!bus.out_valid && n < 20);
    check("latency", n, 3);
    wait_outputs(1);
    pop_check("mul_1p5x2", 32'h00030000, 1'b0);

    // Signs and rounding, back to back.
    send(32'hFFFF8000, 32'h00008000, 0, 0, 0, 0);
    send(32'h00000001, 32'h00008000, 0, 0, 0, 0);
    send(32'h00000001, 32'h00008000, 0, 0, 0, 1);
    send(32'hFFFFFFFF, 32'h00008000, 0, 0, 0, 0);
    send(32'hFFFFFFFF, 32'h00008000, 0, 0, 0, 1);
    wait_outputs(5);
    pop_check("neg_half_x_half", 32'hFFFFC000, 1'b0);
    pop_check("lsb_trunc", 32'h00000000, 1'b0);
    pop_check("lsb_round", 32'h00000001, 1'b0);
    pop_check("neg_lsb_trunc", 32'hFFFFFFFF, 1'b0);
    pop_check("neg_lsb_round", 32'h00000000, 1'b0);

    // Saturation both ways, then a benign beat clears overflow.
    send(32'h7FFF0000, 32'h00020000, 0, 0, 0, 0);
    send(32'h80000000, 32'h00020000, 0, 0, 0, 0);
    send(32'h00010000, 32'h00010000, 0, 0, 0, 0);
    wait_outputs(3);
    pop_check("sat_pos", 32'h7FFFFFFF, 1'b1);
    pop_check("sat_neg", 32'h80000000, 1'b1);
    pop_check("after_sat", 32'h00010000, 1'b0);

    // Four-beat group of 0.25 sums to 1.0 with exactly one output.
    send(32'h00010000, 32'h00004000, 1, 1, 0, 0);
    send(32'h00010000, 32'h00004000, 1, 0, 0, 0);
    send(32'h00010000, 32'h00004000, 1, 0, 0, 0);
    send(32'h00010000, 32'h00004000, 1, 0, 1, 0);
    wait_outputs(1);
    idle(6);
    check("acc_group_outputs", got_res.size(), 1);
    pop_check("acc_group", 32'h00010000, 1'b0);
    send(32'h00010000, 32'h00004000, 1, 1, 1, 0);
    wait_outputs(1);
    pop_check("acc_single", 32'h00004000, 1'b0);

    // Multiply beat inside an open group leaves the accumulator alone.
    send(32'h00010000, 32'h00010000, 1, 1, 0, 0);
    send(32'h00020000, 32'h00020000, 0, 0, 0, 0);
    send(32'h00010000, 32'h00010000, 1, 0, 1, 0);
    wait_outputs(2);
    pop_check("mix_mul", 32'h00040000, 1'b0);
    pop_check("mix_acc", 32'h00020000, 1'b0);

    // A first mid-group restarts; a group without first starts from zero.
    send(32'h00010000, 32'h00010000, 1, 1, 0, 0);
    send(32'h00008000, 32'h00010000, 1, 1, 1, 0);
    send(32'h00010000, 32'h00004000, 1, 0, 1, 0);
    wait_outputs(2);
    pop_check("restart_group", 32'h00008000, 1'b0);
    pop_check("no_first_group", 32'h00004000, 1'b0);

    // Guard bits hold 65534.0 exactly; only the final narrowing clamps.
    send(32'h7FFF0000, 32'h00010000, 1, 1, 0, 0);
    send(32'h7FFF0000, 32'h00010000, 1, 0, 1, 0);
    wait_outputs(1);
    pop_check("acc_final_sat", 32'h7FFFFFFF, 1'b1);

    // Backpressure: 20 beats of k*1.0 with random out_ready and a 5-cycle low stretch.
    bp_phase = 1'b1;
    sent = 0;
    cyc  = 0;
    while (got_res.size() < 20 && cyc < 400) begin
      if (cyc >= 6 && cyc < 11)  bus.out_ready = 1'b0;
      else if (sent >= 20)       bus.out_ready = 1'b1;
      else                       bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        bus.dataa = 32'(sent + 1) << 16; bus.datab = 32'h00010000;
        bus.acc_mode = 1'b0; bus.first = 1'b0; bus.last = 1'b0; bus.round_mode = 1'b0;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      acc_ok = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc_ok) sent++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bp_phase      = 1'b0;
    check("bp_count", got_res.size(), 20);
    for (int k = 0; k < 20; k++) pop_check($sformatf("bp_%0d", k), 32'(k + 1) << 16, 1'b0);

    // Reset in the middle of a group: nothing from the aborted beats survives.
    send(32'h00010000, 32'h00010000, 1, 1, 0, 0);
    send(32'h00010000, 32'h00010000, 1, 0, 0, 0);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(32'h00010000, 32'h00010000, 1, 1, 0, 0);
    send(32'h00010000, 32'h00010000, 1, 0, 1, 0);
    wait_outputs(1);
    idle(6);
    check("post_rst_outputs", got_res.size(), 1);
    pop_check("post_rst_group", 32'h00020000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
